display_scan_controller: RTL and testbench

Upstream feeder for the BCD-to-cathode decoder on the 4-digit seven-segment display. It accepts a binary value and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits: each refresh slot presents one digit on `digit`, which drives the decoder input, and asserts the matching active-low `anode`.

---
 rtl/display_pkg.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 96 +++++++++
 rtl/display_scan_controller.sv | 82 ++++++++
 tb/tb_display_scan_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the 4-digit seven-segment scan controller.
package display_pkg;

    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned MAX_DISPLAY = 9999;

    localparam logic [NUM_DIGITS-1:0] ANODE_ALL_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: saturates the input to 9999 and produces
// four packed BCD digits BIN_WIDTH+1 cycles after start is accepted.
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          bcd,
    output logic                 ovf
);

    localparam int unsigned BCD_W = NUM_DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH);
    localparam logic [BIN_WIDTH-1:0] SAT_VALUE = BIN_WIDTH'(MAX_DISPLAY);
    localparam logic [CNT_W-1:0]     LAST_STEP = CNT_W'(BIN_WIDTH - 1);

    conv_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d, adj_c;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic                 busy_q, busy_d;
    logic                 ovf_q, ovf_d;

    // Add-3 correction on every BCD digit that has reached 5.
    always_comb begin
        adj_c = bcd_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d   = (bin > SAT_VALUE);
                    bin_d   = (bin > SAT_VALUE) ? SAT_VALUE : bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj_c, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = busy_q;
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/display_scan_controller.sv
// Converts a binary value to BCD and time-multiplexes the four digits onto an
// active-low anode bus. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int unsigned BIN_WIDTH   = 14,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_WIDTH-1:0]  value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [3:0]            digit,
    output logic [NUM_DIGITS-1:0] anode
);

    localparam int unsigned PRE_W  = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned DISP_W = NUM_DIGITS * 4;
    localparam logic [PRE_W-1:0]      PRE_LAST    = PRE_W'(REFRESH_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_SLOT0 = ~NUM_DIGITS'(1);

    logic                  conv_done;
    logic [DISP_W-1:0]     conv_bcd;
    logic [DISP_W-1:0]     disp_q, disp_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    bcd_digit_t            digit_q, digit_d;
    logic                  slot_end;

    bin_to_bcd_seq #(
        .BIN_WIDTH(BIN_WIDTH)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (load),
        .bin   (value),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q  <= '0;
            pre_q   <= '0;
            idx_q   <= '0;
            anode_q <= ANODE_SLOT0;
            digit_q <= '0;
        end else begin
            disp_q  <= disp_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            digit_q <= digit_d;
        end
    end

    // Outputs are computed from next-state values so a DONE landing on a slot
    // change shows the new digit on the very same edge.
    always_comb begin
        slot_end = (pre_q == PRE_LAST);
        disp_d   = conv_done ? conv_bcd : disp_q;
        pre_d    = slot_end ? '0 : pre_q + 1'b1;
        idx_d    = slot_end ? idx_q + 1'b1 : idx_q;
        digit_d  = disp_d[{idx_d, 2'b00} +: 4];
        anode_d  = ~(NUM_DIGITS'(1) << idx_d);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_d != '0) && ((disp_d >> {idx_d, 2'b00}) == '0)) begin
            anode_d = ANODE_ALL_OFF;
        end
`endif
    end

    assign anode = anode_q;
    assign digit = digit_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller with a 4-cycle refresh slot.
module tb_display_scan_controller;

    localparam int unsigned BW = 14;
    localparam int unsigned RD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [BW-1:0] value = '0;
    logic          busy;
    logic          overflow;
    logic [3:0]    digit;
    logic [3:0]    anode;

    display_scan_controller #(
        .BIN_WIDTH   (BW),
        .REFRESH_DIV (RD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .overflow (overflow),
        .digit    (digit),
        .anode    (anode)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          conv;
        logic [15:0] bcd;
        logic        ovf;
        int          busy_len;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   pushed = 0;
    int   mon_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] exp_anode(input logic [15:0] bcd, input int s);
        logic [3:0] one;
        one = 4'b0001;
`ifdef LEADING_ZERO_BLANK_EN
        if (s > 0 && (bcd >> (4 * s)) == 16'd0) return 4'b1111;
`endif
        return ~(one << s);
    endfunction

    function automatic logic [3:0] exp_digit(input logic [15:0] bcd, input int s);
        logic [15:0] t;
        t = bcd >> (4 * s);
        return t[3:0];
    endfunction

    task automatic push_exp(input bit conv, input logic [15:0] bcd, input logic ovf);
        exp_t r;
        r.conv = conv;
        r.bcd = bcd;
        r.ovf = ovf;
        r.busy_len = int'(BW) + 1;
        exp_q.push_back(r);
        pushed++;
    endtask

    task automatic do_load(input logic [BW-1:0] v);
        @(negedge clk);
        load = 1'b1;
        value = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_mon();
        int n;
        n = 0;
        while (mon_done != pushed && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("monitor_progress", 32'(mon_done), 32'(pushed));
    endtask

    // Monitor: pops one expectation per conversion/idle record and checks a full scan.
    initial begin
        exp_t       r;
        int         n;
        int         len;
        logic [3:0] prev;
        bit         found;
        bit         mism;
        logic [7:0] act;
        logic [7:0] expv;
        forever begin
            while (exp_q.size() == 0) @(negedge clk);
            r = exp_q.pop_front();
            if (r.conv) begin
                n = 0;
                while (!busy && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("busy_rise", 32'(busy), 32'd1);
                len = 0;
                while (busy && len < 40) begin
                    len++;
                    @(negedge clk);
                end
                check("busy_len", 32'(len), 32'(r.busy_len));
                check("overflow", 32'(overflow), 32'(r.ovf));
            end
            n = 0;
            found = 1'b0;
            prev = anode;
            while (!found && n < 40) begin
                @(negedge clk);
                n++;
                if (anode == 4'b1110 && prev != 4'b1110) found = 1'b1;
                prev = anode;
            end
            check("slot0_found", 32'(found), 32'd1);
            for (int s = 0; s < 4; s++) begin
                mism = 1'b0;
                expv = {exp_anode(r.bcd, s), exp_digit(r.bcd, s)};
                act = expv;
                for (int c = 0; c < int'(RD); c++) begin
                    if (s != 0 || c != 0) @(negedge clk);
                    if (!mism && {anode, digit} !== expv) begin
                        mism = 1'b1;
                        act = {anode, digit};
                    end
                end
                if (!mism) act = {anode, digit};
                check($sformatf("slot%0d_anode_digit", s), 32'(act), 32'(expv));
            end
            mon_done++;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_anode", 32'(anode), 32'hE);
        check("rst_digit", 32'(digit), 32'd0);
        push_exp(1'b0, 16'h0000, 1'b0);
        wait_mon();

        push_exp(1'b1, 16'h1234, 1'b0);
        do_load(BW'(1234));
        wait_mon();

        push_exp(1'b1, 16'h9999, 1'b1);
        do_load(BW'(16383));
        wait_mon();

        push_exp(1'b1, 16'h0042, 1'b0);
        do_load(BW'(42));
        repeat (3) @(negedge clk);
        do_load(BW'(777));
        wait_mon();

        push_exp(1'b1, 16'h0777, 1'b0);
        do_load(BW'(777));
        wait_mon();

        push_exp(1'b1, 16'h9999, 1'b0);
        do_load(BW'(9999));
        wait_mon();

        push_exp(1'b1, 16'h9999, 1'b1);
        do_load(BW'(10000));
        wait_mon();

        do_load(BW'(5678));
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_anode", 32'(anode), 32'hE);
        check("midrst_digit", 32'(digit), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        push_exp(1'b0, 16'h0000, 1'b0);
        wait_mon();

        push_exp(1'b1, 16'h5678, 1'b0);
        do_load(BW'(5678));
        wait_mon();

        push_exp(1'b1, 16'h0007, 1'b0);
        do_load(BW'(7));
        wait_mon();

        push_exp(1'b1, 16'h0000, 1'b0);
        do_load(BW'(0));
        wait_mon();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
